// File: rtl/npn4_pkg.sv
// Shared types and constants for the 4-input NPN canonicalizer.
// PERM_TAB packs one permutation per byte as {pi3, pi2, pi1, pi0}, in lexicographic order.
package npn4_pkg;

    localparam int TT_W      = 16;
    localparam int NUM_STEPS = 384;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [0:23][7:0] PERM_TAB = {
        8'hE4, 8'hB4, 8'hD8, 8'h78, 8'h9C, 8'h6C,
        8'hE1, 8'hB1, 8'hC9, 8'h39, 8'h8D, 8'h2D,
        8'hD2, 8'h72, 8'hC6, 8'h36, 8'h4E, 8'h1E,
        8'h93, 8'h63, 8'h87, 8'h27, 8'h4B, 8'h1B
    };

    // Source variable index feeding bit j of the permuted minterm.
    function automatic logic [1:0] perm_elem(input logic [4:0] p, input int j);
        logic [7:0] ent;
        ent = PERM_TAB[p];
        return ent[2*j +: 2];
    endfunction

endpackage

// File: rtl/npn4_apply.sv
// Combinational transform: g[m] = tt[m'], where m'[j] = m[pi_p(j)] ^ n[j].
// Purely combinational, no handshake.
module npn4_apply
    import npn4_pkg::*;
(
    input  logic [TT_W-1:0] tt,
    input  logic [4:0]      p,
    input  logic [3:0]      n,
    output logic [TT_W-1:0] g
);

    always_comb begin
        logic [3:0] mi;
        logic [3:0] mp;
        g  = '0;
        mi = '0;
        mp = '0;
        for (int m = 0; m < TT_W; m++) begin
            mi = 4'(m);
            for (int j = 0; j < 4; j++) begin
                mp[j] = mi[perm_elem(p, j)] ^ n[j];
            end
            g[m] = tt[mp];
        end
    end

endmodule

// File: rtl/npn4_canon.sv
// Serial NPN canonicalizer: sweeps 24 perms x 16 negations x 2 phases and keeps the minimum.
// Latency 384 cycles from accept (385 with PIPE_APPLY=1); output held until out_ready.
// NPN4_XFORM_OUT_EN adds out_perm/out_neg/out_oneg reporting the first minimizing transform.
module npn4_canon
    import npn4_pkg::*;
#(
    parameter int PIPE_APPLY = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [TT_W-1:0] in_tt,
    output logic            out_valid,
    input  logic            out_ready,
`ifdef NPN4_XFORM_OUT_EN
    output logic [4:0]      out_perm,
    output logic [3:0]      out_neg,
    output logic            out_oneg,
`endif
    output logic [TT_W-1:0] out_tt
);

    state_t          state_q, state_d;
    logic [TT_W-1:0] tt_q, tt_d;
    logic [TT_W-1:0] best_q, best_d;
    logic [8:0]      step_q, step_d;
    logic            issued_q, issued_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic [TT_W-1:0] out_tt_q, out_tt_d;
`ifdef NPN4_XFORM_OUT_EN
    logic [8:0]      bstep_q, bstep_d;
    logic            boneg_q, boneg_d;
    logic [8:0]      out_step_q, out_step_d;
    logic            out_oneg_q, out_oneg_d;
`endif

    logic [TT_W-1:0] g;
    logic            issue;
    logic [TT_W-1:0] cmp_g;
    logic            cmp_vld;
    logic [8:0]      cmp_step;
    logic            accept;

    assign issue  = (state_q == RUN) && !issued_q;
    assign accept = (state_q == IDLE) && in_valid && in_ready_q;

    npn4_apply u_apply (
        .tt (tt_q),
        .p  (step_q[8:4]),
        .n  (step_q[3:0]),
        .g  (g)
    );

    generate
        if (PIPE_APPLY != 0) begin : g_pipe
            logic [TT_W-1:0] pipe_g_q;
            logic            pipe_vld_q;
            logic [8:0]      pipe_step_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pipe_g_q    <= '0;
                    pipe_vld_q  <= 1'b0;
                    pipe_step_q <= '0;
                end else begin
                    pipe_g_q    <= g;
                    pipe_vld_q  <= issue;
                    pipe_step_q <= step_q;
                end
            end
            assign cmp_g    = pipe_g_q;
            assign cmp_vld  = pipe_vld_q;
            assign cmp_step = pipe_step_q;
        end else begin : g_nopipe
            assign cmp_g    = g;
            assign cmp_vld  = issue;
            assign cmp_step = step_q;
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        tt_d        = tt_q;
        best_d      = best_q;
        step_d      = step_q;
        issued_d    = issued_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_tt_d    = out_tt_q;
`ifdef NPN4_XFORM_OUT_EN
        bstep_d     = bstep_q;
        boneg_d     = boneg_q;
        out_step_d  = out_step_q;
        out_oneg_d  = out_oneg_q;
`endif

        // Plain phase first, then complement against the possibly updated best.
        if (cmp_vld) begin
            if (cmp_g < best_d) begin
                best_d = cmp_g;
`ifdef NPN4_XFORM_OUT_EN
                bstep_d = cmp_step;
                boneg_d = 1'b0;
`endif
            end
            if (~cmp_g < best_d) begin
                best_d = ~cmp_g;
`ifdef NPN4_XFORM_OUT_EN
                bstep_d = cmp_step;
                boneg_d = 1'b1;
`endif
            end
        end

        if (issue) begin
            if (step_q == 9'(NUM_STEPS - 1)) begin
                issued_d = 1'b1;
            end else begin
                step_d = step_q + 9'd1;
            end
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d    = RUN;
                    tt_d       = in_tt;
                    best_d     = in_tt;
                    step_d     = '0;
                    issued_d   = 1'b0;
                    in_ready_d = 1'b0;
`ifdef NPN4_XFORM_OUT_EN
                    bstep_d    = '0;
                    boneg_d    = 1'b0;
`endif
                end
            end
            RUN: begin
                if (cmp_vld && cmp_step == 9'(NUM_STEPS - 1)) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    out_tt_d    = best_d;
`ifdef NPN4_XFORM_OUT_EN
                    out_step_d  = bstep_d;
                    out_oneg_d  = boneg_d;
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            tt_q        <= '0;
            best_q      <= '0;
            step_q      <= '0;
            issued_q    <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_tt_q    <= '0;
`ifdef NPN4_XFORM_OUT_EN
            bstep_q     <= '0;
            boneg_q     <= 1'b0;
            out_step_q  <= '0;
            out_oneg_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            tt_q        <= tt_d;
            best_q      <= best_d;
            step_q      <= step_d;
            issued_q    <= issued_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_tt_q    <= out_tt_d;
`ifdef NPN4_XFORM_OUT_EN
            bstep_q     <= bstep_d;
            boneg_q     <= boneg_d;
            out_step_q  <= out_step_d;
            out_oneg_q  <= out_oneg_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_tt    = out_tt_q;
`ifdef NPN4_XFORM_OUT_EN
    assign out_perm  = out_step_q[8:4];
    assign out_neg   = out_step_q[3:0];
    assign out_oneg  = out_oneg_q;
`endif

endmodule

// File: tb/tb_npn4_canon.sv
// Bench for npn4_canon: directed vectors, NPN-class invariance, stall and async reset.
// Expected results come from a brute-force class-minimum model built on its own permutation list.
module tb_npn4_canon;

    localparam int PIPE = 0;
    localparam int LAT  = 384 + PIPE;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] in_tt;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_tt;
`ifdef NPN4_XFORM_OUT_EN
    logic [4:0]  out_perm;
    logic [3:0]  out_neg;
    logic        out_oneg;
`endif

    npn4_canon #(.PIPE_APPLY(PIPE)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_tt     (in_tt),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef NPN4_XFORM_OUT_EN
        .out_perm  (out_perm),
        .out_neg   (out_neg),
        .out_oneg  (out_oneg),
`endif
        .out_tt    (out_tt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int perms[24][4];

    logic [15:0] exp_tt;
    int          exp_p, exp_n, exp_o;
    logic        armed = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [15:0] xform(input logic [15:0] tt, input int p, input int n);
        logic [15:0] g;
        for (int m = 0; m < 16; m++) begin
            int mp;
            mp = 0;
            for (int j = 0; j < 4; j++) begin
                mp += (((m >> perms[p][j]) & 1) ^ ((n >> j) & 1)) << j;
            end
            g[m] = tt[mp];
        end
        return g;
    endfunction

    task automatic model(input logic [15:0] tt, output logic [15:0] best,
                         output int bp, output int bn, output int bo);
        best = tt; bp = 0; bn = 0; bo = 0;
        for (int p = 0; p < 24; p++) begin
            for (int n = 0; n < 16; n++) begin
                logic [15:0] g;
                g = xform(tt, p, n);
                if (g < best) begin best = g; bp = p; bn = n; bo = 0; end
                if (~g < best) begin best = ~g; bp = p; bn = n; bo = 1; end
            end
        end
    endtask

    // Whenever a result is presented it must equal the model's class representative.
    always @(negedge clk) begin
        if (!rst && armed && out_valid) begin
            chk("out_tt", out_tt, exp_tt);
            chk("in_ready_while_valid", in_ready, 1'b0);
`ifdef NPN4_XFORM_OUT_EN
            chk("out_perm", out_perm, exp_p);
            chk("out_neg", out_neg, exp_n);
            chk("out_oneg", out_oneg, exp_o);
`endif
        end
    end

    task automatic start_req(input logic [15:0] tt);
        int w;
        model(tt, exp_tt, exp_p, exp_n, exp_o);
        armed = 1'b1;
        @(negedge clk);
        w = 0;
        while (!in_ready && w < 10) begin @(negedge clk); w++; end
        chk("in_ready_idle", in_ready, 1'b1);
        in_valid = 1'b1;
        in_tt    = tt;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic run_req(input logic [15:0] tt, input int hold, output logic [15:0] got);
        int cyc;
        start_req(tt);
        cyc = 0;
        while (!out_valid && cyc < LAT + 10) begin
            @(posedge clk); cyc++; #1;
        end
        chk("latency", cyc, LAT);
        got = out_tt;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("stall_valid", out_valid, 1'b1);
            chk("stall_tt", out_tt, got);
            chk("stall_in_ready", in_ready, 1'b0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk("in_ready_after", in_ready, 1'b1);
        chk("valid_after", out_valid, 1'b0);
    endtask

    initial begin
        logic [15:0] got, first, m_best, base, t;
        int bp, bn, bo, idx;
        logic [15:0] dir_in  [5];
        logic [15:0] dir_exp [5];

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_tt = '0;

        idx = 0;
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
                for (int c = 0; c < 4; c++)
                    for (int d = 0; d < 4; d++)
                        if (a != b && a != c && a != d && b != c && b != d && c != d) begin
                            perms[idx][0] = a; perms[idx][1] = b;
                            perms[idx][2] = c; perms[idx][3] = d;
                            idx++;
                        end

        dir_in  = '{16'hAAAA, 16'h8000, 16'hFFFF, 16'h0000, 16'h6996};
        dir_exp = '{16'h00FF, 16'h0001, 16'h0000, 16'h0000, 16'h6996};

        // Pin the model itself to hand-derived representatives.
        for (int i = 0; i < 5; i++) begin
            model(dir_in[i], m_best, bp, bn, bo);
            chk("model_literal", m_best, dir_exp[i]);
        end
        model(16'h0000, m_best, bp, bn, bo);
        chk("model_zero_xform", {bp[4:0], bn[3:0], bo[0]}, 10'd0);
        chk("model_perm23", {perms[23][0], perms[23][1], perms[23][2], perms[23][3]},
            {32'd3, 32'd2, 32'd1, 32'd0});

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_tt", out_tt, 16'h0000);
`ifdef NPN4_XFORM_OUT_EN
        chk("rst_xform", {out_perm, out_neg, out_oneg}, 10'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            run_req(dir_in[i], 0, got);
            chk("directed", got, dir_exp[i]);
        end

        // XOR4 class under random NPN transforms.
        for (int k = 0; k < 12; k++) begin
            t = xform(16'h6996, $urandom_range(0, 23), $urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) t = ~t;
            run_req(t, 0, got);
            chk("xor4_class", got, 16'h6996);
        end

        // A random function: every transformed form must land on the same representative.
        base = 16'($urandom);
        run_req(base, 0, first);
        for (int k = 0; k < 11; k++) begin
            t = xform(base, $urandom_range(0, 23), $urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) t = ~t;
            run_req(t, 0, got);
            chk("rand_class", got, first);
        end

        for (int k = 0; k < 3; k++) begin
            run_req(16'($urandom), 0, got);
        end

        run_req(16'h1234, 50, got);

        // Asynchronous reset mid-sweep discards the request.
        start_req(16'h0F31);
        repeat (200) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("post_arst_idle", out_valid, 1'b0);
        run_req(16'h8000, 0, got);
        chk("post_arst_result", got, 16'h0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
